// File: rtl/fpu_regfile_fcsr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_regfile_fcsr_if : read/write/issue/CSR bundle of the FP register file    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fpu_regfile_fcsr_if #(
    parameter int FLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 3
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_sel;
    logic [NRD*FLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;

    logic                fpu_wen;
    logic [AW-1:0]       fpu_rd;
    logic [FLEN-1:0]     fpu_wdata;
    logic [4:0]          fpu_flags;

    logic                ld_wen;
    logic [AW-1:0]       ld_rd;
    logic [FLEN-1:0]     ld_wdata;

    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_stall;

    logic [1:0]          csr_sel;
    logic                csr_wen;
    logic [7:0]          csr_wdata;
    logic [7:0]          csr_rdata;
    logic [2:0]          frm;
    logic                frm_invalid;
    logic                wr_conflict;

    modport master (
        output rs_sel,
        input  rs_data, rs_busy,
        output fpu_wen, fpu_rd, fpu_wdata, fpu_flags,
        output ld_wen, ld_rd, ld_wdata,
        output issue_valid, issue_rd,
        input  issue_stall,
        output csr_sel, csr_wen, csr_wdata,
        input  csr_rdata, frm, frm_invalid, wr_conflict
    );

    modport slave (
        input  rs_sel,
        output rs_data, rs_busy,
        input  fpu_wen, fpu_rd, fpu_wdata, fpu_flags,
        input  ld_wen, ld_rd, ld_wdata,
        input  issue_valid, issue_rd,
        output issue_stall,
        input  csr_sel, csr_wen, csr_wdata,
        output csr_rdata, frm, frm_invalid, wr_conflict
    );
endinterface
`default_nettype wire

// File: rtl/fpu_regfile_fcsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_regfile_fcsr : FP register file, 2 write / NRD bypassed read ports,      |
// | fcsr (frm + sticky fflags) and per-register pending scoreboard.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fpu_regfile_fcsr #(
    parameter int FLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    fpu_regfile_fcsr_if.slave    bus
);
    localparam int            AW           = $clog2(NREGS);
    localparam int            c_DEPTH      = 1 << AW;
    localparam logic [AW:0]   c_NREGS_W    = (AW+1)'(NREGS);
    localparam logic [1:0]    c_CSR_NONE   = 2'b00;
    localparam logic [1:0]    c_CSR_FFLAGS = 2'b01;
    localparam logic [1:0]    c_CSR_FRM    = 2'b10;
    localparam logic [1:0]    c_CSR_FCSR   = 2'b11;

    logic [FLEN-1:0]    r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;
    logic [4:0]         r_fflags;
    logic [2:0]         r_frm;
    logic               r_conflict;

    logic               w_fpu_ok;
    logic               w_ld_ok;
    logic               w_coll;
    logic               w_ld_commit;
    logic               w_issue_ok;
    logic               w_stall;
    logic [c_DEPTH-1:0] w_pend_set;
    logic [c_DEPTH-1:0] w_pend_clr;
    logic [c_DEPTH-1:0] w_pend_nxt;
    logic [4:0]         w_fflags_nxt;
    logic [2:0]         w_frm_nxt;

    function automatic logic f_in_range(input logic [AW-1:0] idx);
        return ({1'b0, idx} < c_NREGS_W);
    endfunction

    assign w_fpu_ok    = bus.fpu_wen & f_in_range(bus.fpu_rd);
    assign w_ld_ok     = bus.ld_wen  & f_in_range(bus.ld_rd);
    assign w_coll      = w_fpu_ok & w_ld_ok & (bus.fpu_rd == bus.ld_rd);
    assign w_ld_commit = w_ld_ok & ~w_coll;

    assign w_stall     = bus.issue_valid & r_pend[bus.issue_rd];
    assign w_issue_ok  = bus.issue_valid & ~w_stall & f_in_range(bus.issue_rd);
    assign bus.issue_stall = w_stall;

    // A dropped colliding load still retires its rd, so it clears pending too.
    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (w_fpu_ok)   w_pend_clr[bus.fpu_rd]   = 1'b1;
        if (w_ld_ok)    w_pend_clr[bus.ld_rd]    = 1'b1;
        if (w_issue_ok) w_pend_set[bus.issue_rd] = 1'b1;
        w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_fpu_ok)    r_regs[bus.fpu_rd] <= bus.fpu_wdata;
            if (w_ld_commit) r_regs[bus.ld_rd]  <= bus.ld_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   w_sel;
            logic            w_hit_fpu;
            logic            w_hit_ld;
            logic [FLEN-1:0] w_data;

            assign w_sel     = bus.rs_sel[gi*AW +: AW];
            assign w_hit_fpu = w_fpu_ok & (bus.fpu_rd == w_sel);
            assign w_hit_ld  = w_ld_ok  & (bus.ld_rd  == w_sel);

            always_comb begin
                w_data = '0;
                if (f_in_range(w_sel)) begin
                    if (w_hit_fpu)     w_data = bus.fpu_wdata;
                    else if (w_hit_ld) w_data = bus.ld_wdata;
                    else               w_data = r_regs[w_sel];
                end
            end

            assign bus.rs_data[gi*FLEN +: FLEN] = w_data;
            assign bus.rs_busy[gi] = r_pend[w_sel] & ~(w_hit_fpu | w_hit_ld);
        end
    endgenerate

    always_comb begin
        w_fflags_nxt = r_fflags;
        w_frm_nxt    = r_frm;
        if (bus.csr_wen) begin
            case (bus.csr_sel)
                c_CSR_FFLAGS: w_fflags_nxt = bus.csr_wdata[4:0];
                c_CSR_FRM:    w_frm_nxt    = bus.csr_wdata[2:0];
                c_CSR_FCSR: begin
                    w_fflags_nxt = bus.csr_wdata[4:0];
                    w_frm_nxt    = bus.csr_wdata[7:5];
                end
                default: ;
            endcase
        end
        // Accrued exceptions OR in after a software write in the same cycle.
        if (bus.fpu_wen) w_fflags_nxt = w_fflags_nxt | bus.fpu_flags;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_pend     <= '0;
            r_fflags   <= '0;
            r_frm      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_fflags   <= w_fflags_nxt;
            r_frm      <= w_frm_nxt;
            r_conflict <= w_coll;
        end
    end

    always_comb begin
        bus.csr_rdata = 8'h00;
        case (bus.csr_sel)
            c_CSR_NONE:   bus.csr_rdata = 8'h00;
            c_CSR_FFLAGS: bus.csr_rdata = {3'b000, r_fflags};
            c_CSR_FRM:    bus.csr_rdata = {5'b00000, r_frm};
            c_CSR_FCSR:   bus.csr_rdata = {r_frm, r_fflags};
            default:      bus.csr_rdata = 8'h00;
        endcase
    end

    assign bus.frm         = r_frm;
    assign bus.frm_invalid = (r_frm == 3'd5) | (r_frm == 3'd6) | (r_frm == 3'd7);
    assign bus.wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: doc/fpu_regfile_fcsr.md
Name: fpu_regfile_fcsr

Overview:
Parametrised floating-point register file with an integrated fcsr (frm + accrued fflags) and a per-register pending scoreboard. It has two write ports (FPU writeback, memory load) and NRD bypassed read ports; NRD=3 serves fused multiply-add rs3. It sits between the decode/issue stage, the FPU datapath and the load path. It replaces the fixed 2-read / single-write FP register signal bundle.

Parameters:
FLEN, 32, data width of each FP register (32 or 64)
NREGS, 32, number of FP registers (2..32, power of two not required)
NRD, 3, number of read ports (1..4)
AW, $clog2(NREGS), register index width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
n_rst  input  1  synchronous active-low reset
rs_sel  input  NRD*AW  read indices, port i at [i*AW +: AW]
rs_data  output  NRD*FLEN  read data, port i at [i*FLEN +: FLEN]
rs_busy  output  NRD  port i's register has a pending write
fpu_wen  input  1  FPU writeback enable
fpu_rd  input  AW  FPU destination
fpu_wdata  input  FLEN  FPU result
fpu_flags  input  5  {NV,DZ,OF,UF,NX} raised by this FPU result
ld_wen  input  1  load writeback enable
ld_rd  input  AW  load destination
ld_wdata  input  FLEN  load data
issue_valid  input  1  FP instruction with FP destination issuing
issue_rd  input  AW  its destination
issue_stall  output  1  WAW hazard, issue must hold
csr_sel  input  2  00 none, 01 fflags, 10 frm, 11 fcsr
csr_wen  input  1  CSR write strobe (ignored when csr_sel=00)
csr_wdata  input  8  CSR write value, right-aligned
csr_rdata  output  8  selected CSR value, zero-extended
frm  output  3  current dynamic rounding mode
frm_invalid  output  1  frm is 5, 6 or 7 (reserved)
wr_conflict  output  1  registered pulse: same-rd collision last cycle

Behaviour:
- Reset (n_rst=0 at edge): all registers 0, fflags=0, frm=0, pending=0, wr_conflict=0. Combinational outputs follow the reset state in the next cycle. Reset dominates every other input, including mid-operation writes and CSR writes.
- f0 is an ordinary writable register; there is no hardwired zero.
- Writes: both ports commit at the edge when enabled.
- Same-rd write collision (fpu_wen & ld_wen & fpu_rd==ld_rd): FPU data wins, the load is dropped, and wr_conflict=1 for exactly the following cycle.
- Writes with index >= NREGS are ignored.
- Reads are combinational with same-cycle bypass:
  - FPU write to rs_sel[i] this cycle: rs_data[i]=fpu_wdata.
  - Otherwise, load write to rs_sel[i] this cycle: rs_data[i]=ld_wdata.
  - Otherwise: the stored value.
  - Index >= NREGS reads 0.
- Scoreboard:
  - issue_valid & !issue_stall sets pending[issue_rd].
  - Any accepted write (fpu or ld, including the dropped colliding load) clears pending[rd].
  - Set and clear of the same index in one cycle: set wins.
- issue_stall = issue_valid & pending[issue_rd] (combinational). A stalled issue sets nothing.
- rs_busy[i] = pending[rs_sel[i]] & !(write to rs_sel[i] this cycle). A bypassed value is therefore not busy.
- fflags next value = (csr_wen & csr_sel∈{01,11} ? csr_wdata[4:0] : fflags) | (fpu_wen ? fpu_flags : 0). Flags are sticky and only a CSR write clears them. A CSR write and FPU flags in the same cycle leave the OR of both.
- frm next value = csr_wen & csr_sel==10 ? csr_wdata[2:0] : csr_wen & csr_sel==11 ? csr_wdata[7:5] : frm.
- Writing a reserved frm value is stored as written; frm_invalid flags it.
- csr_rdata (combinational, reflects state before the edge):
  - 01: {3'b0,fflags}
  - 10: {5'b0,frm}
  - 11: {frm,fflags}
  - 00: 0

Test Plan:
- Reset mid-write: fpu_wen=1 rd=3 with n_rst=0 → f3 reads 0, fflags=0, pending=0 the next cycle.
- Write/bypass: fpu_wen rd=5 data=0x3F800000 with rs_sel[0]=5 in the same cycle → rs_data[0]=0x3F800000 that cycle and after the edge.
- Collision: fpu rd=7 data=0x40000000, ld rd=7 data=0x11111111 → f7=0x40000000, wr_conflict=1 for one cycle then 0.
- Scoreboard: issue rd=2 → next cycle issue rd=2 gives issue_stall=1 and rs_busy=1 for rs_sel=2. ld_wen rd=2 that cycle → rs_busy=0. Next cycle issue is accepted.
- Flags: fpu_flags=5'b00001, then 5'b10000 → csr_rdata(01)=0x11. csr write fflags=0 with fpu_flags=5'b00100 in the same cycle → 0x04.
- fcsr: write 0xE3 to sel 11 → frm=7, frm_invalid=1, fflags=0x03, csr_rdata(11)=0xE3. Write frm=1 via sel 10 → frm_invalid=0.
